// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode encodings, ID/EX register layout
// and per-opcode register-usage helpers.
package decode_stage_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        illegal;
  } idex_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J layout from the opcode
// and sign-extends from inst[31]; formats without an immediate yield 0.
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes IF/ID, drives register-file reads, merges the WB
// bypass, detects load-use hazards and owns the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit BYPASS_EN   = 1'b1,
  parameter bit CHK_ILLEGAL = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        IF_VALID,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_INST,
  output logic [4:0]  RDADDR_1,
  input  logic [31:0] RDDATA_1,
  output logic [4:0]  RDADDR_2,
  input  logic [31:0] RDDATA_2,
  input  logic        WB_WRVALID,
  input  logic [4:0]  WB_WRADDR,
  input  logic [31:0] WB_WRDATA,
  output logic        HAZARD_STALL,
  output logic        EX_VALID,
  output logic [31:0] EX_PC,
  output logic [6:0]  EX_OPCODE,
  output logic [2:0]  EX_FUNCT3,
  output logic [6:0]  EX_FUNCT7,
  output logic [4:0]  EX_RD,
  output logic [4:0]  EX_RS1ADDR,
  output logic [4:0]  EX_RS2ADDR,
  output logic [31:0] EX_RS1DATA,
  output logic [31:0] EX_RS2DATA,
  output logic [31:0] EX_IMM,
  output logic        EX_ILLEGAL
);

  logic [6:0]  opc;
  logic [31:0] imm;
  logic [31:0] op1, op2;
  idex_t       ex_q, ex_d, cap;

  assign opc      = IF_INST[6:0];
  assign RDADDR_1 = uses_rs1(opc) ? IF_INST[19:15] : '0;
  assign RDADDR_2 = uses_rs2(opc) ? IF_INST[24:20] : '0;

  imm_gen u_imm_gen (
    .inst (IF_INST),
    .imm  (imm)
  );

  // A WB write to x0 is never forwarded; unused sources read x0 from the file.
  always_comb begin
    op1 = RDDATA_1;
    op2 = RDDATA_2;
    if (BYPASS_EN && WB_WRVALID && (WB_WRADDR != '0)) begin
      if (WB_WRADDR == RDADDR_1) op1 = WB_WRDATA;
      if (WB_WRADDR == RDADDR_2) op2 = WB_WRDATA;
    end
  end

  assign HAZARD_STALL = IF_VALID && ex_q.valid && (ex_q.opcode == OPC_LOAD) &&
                        (ex_q.rd != '0) &&
                        ((ex_q.rd == RDADDR_1) || (ex_q.rd == RDADDR_2));

  always_comb begin
    cap          = '0;
    cap.valid    = IF_VALID;
    cap.pc       = IF_PC;
    cap.opcode   = opc;
    cap.funct3   = IF_INST[14:12];
    cap.funct7   = IF_INST[31:25];
    cap.rd       = writes_rd(opc) ? IF_INST[11:7] : '0;
    cap.rs1_addr = RDADDR_1;
    cap.rs2_addr = RDADDR_2;
    cap.rs1_data = op1;
    cap.rs2_data = op2;
    cap.imm      = imm;
    cap.illegal  = CHK_ILLEGAL && !is_rv32i_opcode(opc);
  end

  // STALL freezes everything (FLUSH included); FLUSH and hazard both insert a bubble.
  always_comb begin
    ex_d = ex_q;
    if (STALL)                      ex_d = ex_q;
    else if (FLUSH || HAZARD_STALL) ex_d = '0;
    else                            ex_d = cap;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign EX_VALID   = ex_q.valid;
  assign EX_PC      = ex_q.pc;
  assign EX_OPCODE  = ex_q.opcode;
  assign EX_FUNCT3  = ex_q.funct3;
  assign EX_FUNCT7  = ex_q.funct7;
  assign EX_RD      = ex_q.rd;
  assign EX_RS1ADDR = ex_q.rs1_addr;
  assign EX_RS2ADDR = ex_q.rs2_addr;
  assign EX_RS1DATA = ex_q.rs1_data;
  assign EX_RS2DATA = ex_q.rs2_data;
  assign EX_IMM     = ex_q.imm;
  assign EX_ILLEGAL = ex_q.illegal;

endmodule
